// File: rtl/pipeline_stage0_prefetch_pkg.sv
// pipeline_stage0_prefetch_pkg: shared constants, output-mux select encoding and depth check
package pipeline_stage0_prefetch_pkg;
    localparam logic [7:0] NOP = 8'h00;
    typedef enum logic [1:0] {
        SEL_NOP,
        SEL_BYPASS,
        SEL_HEAD,
        SEL_REPLAY
    } sel_t;
    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction
endpackage

// File: rtl/pipeline_stage0_prefetch_fetch_queue.sv
// fetch_queue: WIDTH x DEPTH circular buffer with push/pop and synchronous clear
//   clk   : system clock
//   clear : drops every entry and zeroes the pointers on the next edge
//   push  : write din at the tail (caller guarantees !full)
//   pop   : retire the head (caller guarantees !empty)
//   head  : oldest entry, count/full/empty : occupancy
module fetch_queue
    import pipeline_stage0_prefetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);
    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of two >= 2");
    end
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    assign head  = mem[rd_ptr];
    assign full  = count == (PTR_W + 1)'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end
    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        end
    end
endmodule

// File: rtl/pipeline_stage0_prefetch.sv
// pipeline_stage0_prefetch: fetch stage 0 with a prefetch queue, bypass, replay, flush and PC strobes
//   bus_request/fetch_suppress : bus owner and fetch suppression; both high = replay last byte
//   flag_pcraflip              : selects which PC register (pcra0/pcra1) gets the increment strobe
//   flush                      : taken branch, drops queued bytes and the same-cycle bus byte
//   consume                    : stage 1 takes instruction_out this cycle
//   instruction_out/valid      : byte to stage 1
//   inc_pcra0/inc_pcra1        : active-low increment strobes, one low per accepted byte
//   queue_count/fetch_hold     : occupancy and full indication
module pipeline_stage0_prefetch
    import pipeline_stage0_prefetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bus_request,
    input  logic             fetch_suppress,
    input  logic             flag_pcraflip,
    input  logic             flush,
    input  logic             consume,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] instruction_out,
    output logic             instruction_valid,
    output logic             inc_pcra0,
    output logic             inc_pcra1,
    output logic [PTR_W:0]   queue_count,
    output logic             fetch_hold
);
    logic             fetch_byte, replay, bypass_take, accept, push, pop, full, empty;
    logic [WIDTH-1:0] head, last_issued;
    sel_t             sel;
    fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_queue (
        .clk  (clk),
        .clear(reset || flush),
        .push (push),
        .pop  (pop),
        .din  (bus_in),
        .head (head),
        .count(queue_count),
        .full (full),
        .empty(empty)
    );
    assign fetch_byte  = !bus_request && !fetch_suppress && !flush;
    assign replay      = bus_request && fetch_suppress;
    assign bypass_take = empty && fetch_byte && consume && !replay;
    // A byte refused because the queue is full is not accepted, so the PC stays put and it is refetched.
    assign accept      = !reset && fetch_byte && (bypass_take || !full);
    assign push        = accept && !bypass_take;
    assign pop         = consume && !empty && !replay && !flush;
    assign sel         = replay ? SEL_REPLAY : !empty ? SEL_HEAD : fetch_byte ? SEL_BYPASS : SEL_NOP;
    assign instruction_out = sel == SEL_REPLAY ? last_issued :
                             sel == SEL_HEAD   ? head :
                             sel == SEL_BYPASS ? bus_in : WIDTH'(NOP);
    assign instruction_valid = sel != SEL_NOP;
    assign inc_pcra0  = !(accept && !flag_pcraflip);
    assign inc_pcra1  = !(accept && flag_pcraflip);
    assign fetch_hold = full;
    always_ff @(posedge clk) begin
        if (reset || flush) last_issued <= '0;
        else if (consume && instruction_valid && !replay) last_issued <= instruction_out;
    end
endmodule

// File: tb/tb_pipeline_stage0_prefetch.sv
// tb_pipeline_stage0_prefetch: directed and random checks against a queue-based reference model
module tb_pipeline_stage0_prefetch;
    localparam int W = 8;
    localparam int D = 4;
    logic clk = 0;
    logic reset, bus_request, fetch_suppress, flag_pcraflip, flush, consume;
    logic [W-1:0] bus_in, instruction_out;
    logic instruction_valid, inc_pcra0, inc_pcra1, fetch_hold;
    logic [2:0] queue_count;
    int checks = 0;
    int errors = 0;
    logic [W-1:0] mq[$];
    logic [W-1:0] mlast = '0;

    pipeline_stage0_prefetch #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .bus_request(bus_request), .fetch_suppress(fetch_suppress),
        .flag_pcraflip(flag_pcraflip), .flush(flush), .consume(consume), .bus_in(bus_in),
        .instruction_out(instruction_out), .instruction_valid(instruction_valid),
        .inc_pcra0(inc_pcra0), .inc_pcra1(inc_pcra1), .queue_count(queue_count),
        .fetch_hold(fetch_hold)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check combinational outputs mid-cycle, then advance the model and clock.
    task automatic step(input bit r, input bit br, input bit fs, input bit fp, input bit fl,
                        input bit co, input logic [W-1:0] b, input bit do_chk);
        bit fb, rp, ev, acc, byp, tk;
        logic [W-1:0] eo;
        reset = r; bus_request = br; fetch_suppress = fs; flag_pcraflip = fp;
        flush = fl; consume = co; bus_in = b;
        #3;
        fb = !br && !fs && !fl;
        rp = br && fs;
        if (rp) begin eo = mlast; ev = 1; end
        else if (mq.size() > 0) begin eo = mq[0]; ev = 1; end
        else if (fb) begin eo = b; ev = 1; end
        else begin eo = '0; ev = 0; end
        byp = !r && fb && mq.size() == 0 && co;
        acc = !r && fb && (byp || mq.size() < D);
        tk  = co && ev && !rp;
        if (do_chk) begin
            chk("out", {1'b0, instruction_out}, {1'b0, eo});
            chk("valid", {8'd0, instruction_valid}, {8'd0, ev});
            chk("inc0", {8'd0, inc_pcra0}, {8'd0, !(acc && !fp)});
            chk("inc1", {8'd0, inc_pcra1}, {8'd0, !(acc && fp)});
            chk("count", {6'd0, queue_count}, 9'(mq.size()));
            chk("hold", {8'd0, fetch_hold}, {8'd0, mq.size() == D});
        end
        if (r || fl) begin
            mq = {};
            mlast = '0;
        end else begin
            if (tk && mq.size() > 0) void'(mq.pop_front());
            if (acc && !byp) mq.push_back(b);
            if (tk) mlast = eo;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(1, 1, 0, 0, 0, 0, 8'h00, 0);
        step(1, 1, 0, 0, 0, 0, 8'h00, 1);
        step(0, 1, 0, 0, 0, 0, 8'h00, 1);
        // fill to full, fifth byte refused
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 8'h11 + 8'(i), 1);
        chk("t1_count", {6'd0, queue_count}, 9'd4);
        chk("t1_hold", {8'd0, fetch_hold}, 9'd1);
        // drain while data access owns the bus
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 1, 8'h00, 1);
        chk("drain_count", {6'd0, queue_count}, 9'd0);
        // same-cycle bypass
        step(0, 0, 0, 0, 0, 1, 8'hA5, 1);
        chk("t2_count", {6'd0, queue_count}, 9'd0);
        // queue [21,22], issue both while bus busy
        step(0, 0, 0, 0, 0, 0, 8'h21, 1);
        step(0, 0, 0, 0, 0, 0, 8'h22, 1);
        step(0, 1, 0, 0, 0, 1, 8'h00, 1);
        chk("t3_count1", {6'd0, queue_count}, 9'd1);
        step(0, 1, 0, 0, 0, 1, 8'h00, 1);
        chk("t3_count0", {6'd0, queue_count}, 9'd0);
        // replay of 21 leaves the queue untouched
        step(0, 0, 0, 0, 0, 0, 8'h21, 1);
        step(0, 0, 0, 0, 0, 0, 8'h23, 1);
        step(0, 0, 0, 0, 0, 0, 8'h24, 1);
        step(0, 1, 0, 0, 0, 1, 8'h00, 1);
        step(0, 1, 1, 0, 0, 1, 8'h00, 1);
        chk("t4_count", {6'd0, queue_count}, 9'd2);
        // three entries then flush with 77 on the bus
        step(0, 0, 0, 0, 0, 0, 8'h31, 1);
        step(0, 0, 0, 0, 1, 0, 8'h77, 1);
        chk("t5_count", {6'd0, queue_count}, 9'd0);
        step(0, 1, 0, 0, 0, 0, 8'h00, 1);
        // flip selects pcra1, then reset mid-burst
        step(0, 0, 0, 1, 0, 0, 8'h41, 1);
        step(0, 0, 0, 1, 0, 0, 8'h42, 1);
        step(1, 0, 0, 1, 0, 1, 8'h43, 1);
        chk("t6_count", {6'd0, queue_count}, 9'd0);
        step(0, 1, 0, 0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 500; i++)
            step($urandom_range(39) == 0, $urandom_range(2) == 0, $urandom_range(3) == 0,
                 1'($urandom), $urandom_range(19) == 0, 1'($urandom), 8'($urandom), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
